// File: rtl/dsp_mavg_filter.sv
// Moving-average filter between the ADC sample interface and the RX FIFO
// write port. A running sum over an N-entry window (N = 2**TAP_LOG2) is
// updated on every accepted sample. One registered write is issued per result.
// The block also supports bypass, dropped-sample counting and a
// threshold-based sticky interrupt.
module dsp_mavg_filter #(
   parameter int DATA_W   = 8,
   parameter int TAP_LOG2 = 2,
   parameter int ROUND    = 1,
   parameter int CNT_W    = 8
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              enable,
   input  logic              bypass,
   input  logic              adc_valid,
   input  logic [DATA_W-1:0] adc_data,
   input  logic              i_full,
   output logic              o_w_inc,
   output logic [DATA_W-1:0] o_w_data,
   input  logic              irq_en,
   input  logic [CNT_W-1:0]  irq_thresh,
   input  logic              irq_clr,
   output logic              irq,
   output logic [CNT_W-1:0]  drop_cnt,
   output logic [1:0]        dsp_stat
);

   localparam int N      = 1 << TAP_LOG2;
   localparam int SUM_W  = DATA_W + TAP_LOG2;
   localparam int FILL_W = TAP_LOG2 + 1;
   // Half an LSB of the shifted result, added before the shift for round-half-up
   localparam logic [SUM_W:0] RND_ADD = (ROUND != 0) ? (SUM_W + 1)'(N / 2) : '0;

   typedef enum logic [1:0] {
      ST_IDLE = 2'b00,
      ST_FILL = 2'b01,
      ST_RUN  = 2'b10
   } state_t;

   state_t              state_q, state_d;
   logic [DATA_W-1:0]   window_q [N];
   logic [SUM_W-1:0]    sum_q;
   logic [FILL_W-1:0]   fill_q;
   logic                o_w_inc_q;
   logic [DATA_W-1:0]   o_w_data_q;
   logic [CNT_W-1:0]    drop_q;
   logic [CNT_W-1:0]    res_cnt_q, res_cnt_d;
   logic                irq_q, irq_d;

   logic                acc_s;
   logic                drop_s;
   logic                fill_last_s;
   logic                wr_s;
   logic [SUM_W-1:0]    sum_next_s;
   logic [SUM_W:0]      rnd_sum_s;
   logic [DATA_W-1:0]   avg_s;
   logic [CNT_W-1:0]    res_inc_s;
   logic                hit_s;

   // Sample qualification. A sample is only entered once the FSM has left IDLE.
   assign acc_s  = adc_valid & enable & ~i_full & (state_q != ST_IDLE);
   assign drop_s = adc_valid & enable & i_full;

   // Running-sum datapath: the average is taken from the post-update sum
   always_comb begin
      sum_next_s = sum_q + SUM_W'(adc_data) - SUM_W'(window_q[N-1]);
      rnd_sum_s  = {1'b0, sum_next_s} + RND_ADD;
      avg_s      = DATA_W'(rnd_sum_s >> TAP_LOG2);
   end

   // FSM state register
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= ST_IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   // FSM next-state logic
   always_comb begin
      state_d = state_q;
      case (state_q)
         ST_IDLE: begin
            if (enable) state_d = ST_FILL;
            else        state_d = ST_IDLE;
         end
         ST_FILL: begin
            if (!enable)                                       state_d = ST_IDLE;
            else if (acc_s && (fill_q == FILL_W'(N - 1)))      state_d = ST_RUN;
            else                                               state_d = ST_FILL;
         end
         ST_RUN: begin
            if (!enable) state_d = ST_IDLE;
            else         state_d = ST_RUN;
         end
         default: state_d = ST_IDLE;
      endcase
   end

   // FSM output decode: which accepted samples produce a FIFO write
   always_comb begin
      fill_last_s = 1'b0;
      wr_s        = 1'b0;
      case (state_q)
         ST_FILL: begin
            fill_last_s = (fill_q == FILL_W'(N - 1));
            wr_s        = acc_s & (bypass | fill_last_s);
         end
         ST_RUN: begin
            fill_last_s = 1'b0;
            wr_s        = acc_s;
         end
         default: begin
            fill_last_s = 1'b0;
            wr_s        = 1'b0;
         end
      endcase
   end

   // Window shift register, running sum and fill count; cleared whenever disabled
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         for (int i = 0; i < N; i++) window_q[i] <= '0;
         sum_q  <= '0;
         fill_q <= '0;
      end else if (!enable) begin
         for (int i = 0; i < N; i++) window_q[i] <= '0;
         sum_q  <= '0;
         fill_q <= '0;
      end else if (acc_s) begin
         for (int i = N - 1; i > 0; i--) window_q[i] <= window_q[i-1];
         window_q[0] <= adc_data;
         sum_q       <= sum_next_s;
         if (state_q == ST_FILL) fill_q <= fill_q + FILL_W'(1);
      end
   end

   // Registered FIFO write strobe and data; data holds between results
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         o_w_inc_q  <= 1'b0;
         o_w_data_q <= '0;
      end else begin
         o_w_inc_q <= wr_s;
         if (wr_s) o_w_data_q <= bypass ? adc_data : avg_s;
      end
   end

   // Saturating dropped-sample counter, cleared only by reset
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         drop_q <= '0;
      end else if (drop_s && (drop_q != {CNT_W{1'b1}})) begin
         drop_q <= drop_q + CNT_W'(1);
      end
   end

   // Result counter and sticky interrupt next state; a set beats a clear
   always_comb begin
      res_inc_s = res_cnt_q + CNT_W'(1);
      hit_s     = o_w_inc_q && (irq_thresh != '0) && (res_inc_s >= irq_thresh);
      if (!o_w_inc_q) res_cnt_d = res_cnt_q;
      else if (hit_s) res_cnt_d = '0;
      else            res_cnt_d = res_inc_s;
      if (hit_s && irq_en) irq_d = 1'b1;
      else if (irq_clr)    irq_d = 1'b0;
      else                 irq_d = irq_q;
   end

   // Result counter and interrupt registers
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         res_cnt_q <= '0;
         irq_q     <= 1'b0;
      end else begin
         res_cnt_q <= res_cnt_d;
         irq_q     <= irq_d;
      end
   end

   assign o_w_inc  = o_w_inc_q;
   assign o_w_data = o_w_data_q;
   assign irq      = irq_q;
   assign drop_cnt = drop_q;
   assign dsp_stat = state_q;

endmodule
